// File: rtl/arbitro_pulso_pkg.sv
// Shared definitions for the pulse arbiter: FSM state encoding and default sizing.
package arbitro_pulso_pkg;

  localparam int unsigned NPadrao       = 4;
  localparam int unsigned LarguraPadrao = 25;

  typedef enum logic [1:0] {
    StOcioso  = 2'd0,
    StGerando = 2'd1,
    StFim     = 2'd2
  } estado_e;

endpackage

// File: rtl/contador_largura.sv
// Pulse-width counter: cleared while idle, counts up while enabled and
// saturates at LARGURA-1, flagging the last pulse cycle with fim.
module contador_largura
  import arbitro_pulso_pkg::*;
#(
  parameter int unsigned LARGURA = LarguraPadrao
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic habilita,
  output logic fim
);

  localparam int unsigned W = $clog2(LARGURA + 1);
  localparam logic [W-1:0] Ultima = W'(LARGURA - 1);

  logic [W-1:0] conta_q, conta_d;

  // Next count: clear has priority; hold at the last value instead of wrapping.
  always_comb begin
    conta_d = conta_q;
    if (limpa) begin
      conta_d = '0;
    end else if (habilita && !fim) begin
      conta_d = conta_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      conta_q <= '0;
    end else begin
      conta_q <= conta_d;
    end
  end

  assign fim = (conta_q == Ultima);

endmodule

// File: rtl/arbitro_pulso.sv
// Round-robin arbiter for a shared fixed-width pulse generator. The winner
// holds the grant through the pulse and one completion cycle; every output
// is decoded from registered state so no input reaches an output directly.
module arbitro_pulso
  import arbitro_pulso_pkg::*;
#(
  parameter int unsigned N       = NPadrao,
  parameter int unsigned LARGURA = LarguraPadrao
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] pedido,
  input  logic [N-1:0] para,
  output logic [N-1:0] concede,
  output logic         pulso,
  output logic [N-1:0] pronto,
  output logic         interrompido,
  output logic         ocupado
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] UltimoReset = IW'(N - 1);

  estado_e       estado_q, estado_d;
  logic [N-1:0]  concede_q, concede_d;
  logic [IW-1:0] ultimo_q, ultimo_d;
  logic          aborto_q, aborto_d;
  logic          cont_limpa, cont_habilita, cont_fim;
  logic [IW-1:0] vencedor;

  // Scan upward from the requester after the last winner, wrapping at N.
  function automatic logic [IW-1:0] escolhe(input logic [N-1:0]  ped,
                                            input logic [IW-1:0] ult);
    logic [IW-1:0] v;
    logic          achou;
    int unsigned   idx;
    v     = ult;
    achou = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(ult) + k) % N;
      if (!achou && ped[idx[IW-1:0]]) begin
        v     = idx[IW-1:0];
        achou = 1'b1;
      end
    end
    return v;
  endfunction

  assign vencedor = escolhe(pedido, ultimo_q);

  contador_largura #(
    .LARGURA (LARGURA)
  ) u_contador (
    .clock    (clock),
    .reset    (reset),
    .limpa    (cont_limpa),
    .habilita (cont_habilita),
    .fim      (cont_fim)
  );

  // Next-state logic: grant in idle, run/abort the pulse, one completion cycle.
  always_comb begin
    estado_d      = estado_q;
    concede_d     = concede_q;
    ultimo_d      = ultimo_q;
    aborto_d      = aborto_q;
    cont_limpa    = 1'b0;
    cont_habilita = 1'b0;
    unique case (estado_q)
      StOcioso: begin
        cont_limpa = 1'b1;
        if (|pedido) begin
          estado_d            = StGerando;
          concede_d           = '0;
          concede_d[vencedor] = 1'b1;
          ultimo_d            = vencedor;
          aborto_d            = 1'b0;
        end
      end
      StGerando: begin
        cont_habilita = 1'b1;
        // Abort wins over the final count so the strobe reports it.
        if (|(para & concede_q)) begin
          estado_d = StFim;
          aborto_d = 1'b1;
        end else if (cont_fim) begin
          estado_d = StFim;
        end
      end
      StFim: begin
        estado_d  = StOcioso;
        concede_d = '0;
      end
      default: begin
        estado_d  = StOcioso;
        concede_d = '0;
      end
    endcase
  end

  // State, grant and history registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q  <= StOcioso;
      concede_q <= '0;
      ultimo_q  <= UltimoReset;
      aborto_q  <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      concede_q <= concede_d;
      ultimo_q  <= ultimo_d;
      aborto_q  <= aborto_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    concede      = concede_q;
    pulso        = (estado_q == StGerando);
    ocupado      = (estado_q != StOcioso);
    pronto       = (estado_q == StFim) ? concede_q : '0;
    interrompido = (estado_q == StFim) && aborto_q;
  end

endmodule

// File: tb/tb_arbitro_pulso.sv
// Scoreboard bench for arbitro_pulso (N=4, LARGURA=5, 20 ns clock).
module tb_arbitro_pulso;

  localparam int N       = 4;
  localparam int LARGURA = 5;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] pedido = '0;
  logic [N-1:0] para   = '0;
  logic [N-1:0] concede;
  logic         pulso;
  logic [N-1:0] pronto;
  logic         interrompido;
  logic         ocupado;

  always #10 clock = ~clock;

  arbitro_pulso #(
    .N       (N),
    .LARGURA (LARGURA)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .pedido       (pedido),
    .para         (para),
    .concede      (concede),
    .pulso        (pulso),
    .pronto       (pronto),
    .interrompido (interrompido),
    .ocupado      (ocupado)
  );

  // Expected grant at each pulse start; esp = cycles since previous start (0 = unchecked).
  typedef struct packed {
    logic [N-1:0] g;
    logic [7:0]   esp;
  } conc_t;
  // Expected completion: strobe target, abort flag, pulse length.
  typedef struct packed {
    logic [N-1:0] g;
    logic         intr;
    logic [7:0]   len;
  } fim_t;

  conc_t q_conc[$];
  fim_t  q_fim[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic chk_zero  = 1'b0;
  logic fim_teste = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nome, input int atual, input int esperado);
    n_vec++;
    if (atual != esperado) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nome, atual, esperado, cyc);
    end
  endtask

  // Monitor: pulse starts, completions, reset-state probes and the final summary.
  logic pulso_ant   = 1'b0;
  int   len_med     = 0;
  int   ult_inicio  = 0;
  always @(negedge clock) begin
    conc_t ec;
    fim_t  ef;
    if (pulso === 1'b1 && pulso_ant !== 1'b1) begin
      len_med = 1;
      if (q_conc.size() == 0) begin
        chk("grant_unexpected", int'(concede), 0);
      end else begin
        ec = q_conc.pop_front();
        chk("grant_onehot", int'(concede), int'(ec.g));
        if (ec.esp != 0) chk("start_spacing", cyc - ult_inicio, int'(ec.esp));
      end
      ult_inicio = cyc;
    end else if (pulso === 1'b1) begin
      len_med++;
    end
    if (pronto !== '0) begin
      if (q_fim.size() == 0) begin
        chk("pronto_unexpected", int'(pronto), 0);
      end else begin
        ef = q_fim.pop_front();
        chk("pronto", int'(pronto), int'(ef.g));
        chk("interrompido", int'(interrompido), int'(ef.intr));
        chk("pulse_len", len_med, int'(ef.len));
        chk("concede_in_fim", int'(concede), int'(ef.g));
      end
    end
    if (chk_zero) begin
      chk("rst_concede", int'(concede), 0);
      chk("rst_pulso", int'(pulso), 0);
      chk("rst_pronto", int'(pronto), 0);
      chk("rst_interrompido", int'(interrompido), 0);
      chk("rst_ocupado", int'(ocupado), 0);
    end
    pulso_ant = pulso;
    if (fim_teste) begin
      chk("grants_left", q_conc.size(), 0);
      chk("completions_left", q_fim.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic espera_ocioso();
    for (int i = 0; i < 100; i++) begin
      if (ocupado === 1'b0) return;
      tick(1);
    end
    $display("FAIL idle_timeout: ocupado still %b after 100 cycles", ocupado);
    $fatal(1, "arbiter never returned to idle");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic push_conc(input logic [N-1:0] g, input int esp);
    conc_t e;
    e.g   = g;
    e.esp = 8'(esp);
    q_conc.push_back(e);
  endtask

  task automatic push_fim(input logic [N-1:0] g, input logic intr, input int len);
    fim_t e;
    e.g    = g;
    e.intr = intr;
    e.len  = 8'(len);
    q_fim.push_back(e);
  endtask

  initial begin
    // Reset state.
    tick(2);
    chk_zero = 1'b1;
    tick(1);
    chk_zero = 1'b0;
    reset = 1'b1;

    // Single request, one-cycle pedido: full pulse, clean completion.
    pedido = 4'b0001;
    push_conc(4'b0001, 0);
    push_fim(4'b0001, 1'b0, LARGURA);
    tick(1);
    pedido = '0;
    espera_ocioso();

    // All requesting: rotation from requester 0, starts LARGURA+2 apart.
    do_reset();
    pedido = 4'b1111;
    push_conc(4'b0001, 0);
    push_conc(4'b0010, LARGURA + 2);
    push_conc(4'b0100, LARGURA + 2);
    push_conc(4'b1000, LARGURA + 2);
    push_conc(4'b0001, LARGURA + 2);
    push_fim(4'b0001, 1'b0, LARGURA);
    push_fim(4'b0010, 1'b0, LARGURA);
    push_fim(4'b0100, 1'b0, LARGURA);
    push_fim(4'b1000, 1'b0, LARGURA);
    push_fim(4'b0001, 1'b0, LARGURA);
    tick(4 * (LARGURA + 2) + 1);
    pedido = '0;
    espera_ocioso();

    // Abort in the 2nd pulse cycle.
    do_reset();
    pedido = 4'b0001;
    push_conc(4'b0001, 0);
    push_fim(4'b0001, 1'b1, 2);
    tick(1);
    pedido = '0;
    tick(1);
    para = 4'b0001;
    tick(1);
    para = '0;
    espera_ocioso();

    // Abort on a non-granted bit is ignored.
    do_reset();
    para   = 4'b0100;
    pedido = 4'b0001;
    push_conc(4'b0001, 0);
    push_fim(4'b0001, 1'b0, LARGURA);
    tick(1);
    pedido = '0;
    espera_ocioso();
    para = '0;

    // Abort coinciding with the last count: full length, flagged as abort.
    do_reset();
    pedido = 4'b0001;
    push_conc(4'b0001, 0);
    push_fim(4'b0001, 1'b1, LARGURA);
    tick(1);
    pedido = '0;
    tick(LARGURA - 1);
    para = 4'b0001;
    tick(1);
    para = '0;
    espera_ocioso();

    // Reset mid-pulse: no completion, then requester 0 wins first.
    do_reset();
    pedido = 4'b0001;
    push_conc(4'b0001, 0);
    tick(1);
    pedido = '0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk_zero = 1'b1;
    reset    = 1'b1;
    pedido   = 4'b1001;
    push_conc(4'b0001, 0);
    push_fim(4'b0001, 1'b0, LARGURA);
    tick(1);
    chk_zero = 1'b0;
    pedido   = '0;
    espera_ocioso();

    // Sparse request after last winner 0: skips 1 and 2, grants 3.
    pedido = 4'b1001;
    push_conc(4'b1000, 0);
    push_fim(4'b1000, 1'b0, LARGURA);
    tick(1);
    pedido = '0;
    espera_ocioso();

    tick(3);
    fim_teste = 1'b1;
    tick(3);
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global time limit reached");
  end

endmodule

// File: doc/arbitro_pulso.md
ARBITRO_PULSO -- requirements
Module: arbitro_pulso

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the pulse resource, 2..8.
REQ-002 Parameter LARGURA, default 25: pulse width in clock cycles, >=1.
REQ-003 Port clock, input, 1: single system clock; all state updates on rising edge.
REQ-004 Port reset, input, 1: synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-005 Port pedido, input, N: level request per requester; bit i = requester i wants one pulse.
REQ-006 Port para, input, N: abort request; bit i is effective only while requester i holds the grant.
REQ-007 Port concede, output, N: one-hot grant, all-zero when idle.
REQ-008 Port pulso, output, 1: shared pulse output, registered.
REQ-009 Port pronto, output, N: one-cycle completion strobe to the granted requester.
REQ-010 Port interrompido, output, 1: one-cycle strobe, coincident with pronto, when the pulse was aborted.
REQ-011 Port ocupado, output, 1: high whenever state is not OCIOSO.

Function
REQ-012 FSM states: OCIOSO, GERANDO, FIM; all outputs decoded from registered state/grant, no combinational input-to-output path.
REQ-013 OCIOSO, pedido!=0 at edge E0: winner latched into concede, width counter cleared, next state GERANDO; pedido==0: stay.
REQ-014 Winner selection: round-robin, scanning from (ultimo+1) mod N upward with wrap; ultimo updated to winner at E0.
REQ-015 GERANDO: pulso=1; counter increments each cycle; at the edge where counter==LARGURA-1, next state FIM; pulso therefore high exactly LARGURA cycles, first cycle immediately after E0.
REQ-016 GERANDO, para[i]=1 with concede[i]=1: next state FIM, abort flag set; pulso falls at that edge.
REQ-017 para on a non-granted bit, or in OCIOSO/FIM: ignored.
REQ-018 para and final count on the same edge: treated as abort (interrompido=1).
REQ-019 FIM: one cycle; pronto=concede, interrompido=abort flag, concede still held; next state OCIOSO with concede=0.
REQ-020 pedido changes outside OCIOSO are not sampled; dropping pedido after grant does not shorten the pulse.
REQ-021 Minimum spacing between pulse starts: LARGURA+2 cycles (GERANDO, FIM, OCIOSO).
REQ-022 LARGURA=1: exactly one pulso cycle, then FIM.
REQ-023 Counter width: clog2(LARGURA+1) bits; never exceeds LARGURA-1, no wrap.

Reset
REQ-024 reset=0 at an edge, in any state including mid-pulse: next state OCIOSO, counter=0, abort flag=0, ultimo=N-1.
REQ-025 Output values after reset: concede=0, pulso=0, pronto=0, interrompido=0, ocupado=0.
REQ-026 A pulse cut by reset produces no pronto; requester 0 has highest priority on the first arbitration after reset.

Structure
REQ-027 State encoding constants and default N/LARGURA go in the shared definitions package; no other typedefs.
REQ-028 Width counter is a sub-module contador_largura (clear, enable, fim when count==LARGURA-1); arbitration and FSM stay in arbitro_pulso.
REQ-029 Round-robin selection is a combinational function inside arbitro_pulso, registered only via concede/ultimo.

Verification (N=4, LARGURA=5, 20 ns clock)
REQ-030 Reset, then pedido=0001 for one cycle -> concede=0001 from next cycle, pulso high exactly 5 cycles, then pronto=0001 for 1 cycle, interrompido=0, concede=0 after.
REQ-031 pedido=1111 held -> grants 0001,0010,0100,1000,0001 in order, pulse starts 7 cycles apart.
REQ-032 Grant 0001, para=0001 in 2nd pulso cycle -> pulso low next cycle, pronto=0001 and interrompido=1 for 1 cycle.
REQ-033 Grant 0001, para=0100 throughout -> ignored, full 5-cycle pulse, interrompido=0.
REQ-034 para=0001 on 5th pulso cycle -> pulso still 5 cycles, interrompido=1 with pronto.
REQ-035 reset=0 on 3rd pulso cycle -> next cycle all outputs 0, no pronto; then pedido=1001 -> concede=0001.
